// File: rtl/shared_bus_if.sv
// Bundle of N source lanes (req/data/last) plus the single shared valid/ready output bus.
// The arbiter takes the master side; the sources and the sink together form the slave side.
interface shared_bus_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   last;
    logic           bus_ready;
    logic           bus_valid;
    logic [W-1:0]   bus_data;
    logic           bus_last;
    logic [N-1:0]   grant;
    logic           busy;

    modport master (
        input  req, data_in, last, bus_ready,
        output bus_valid, bus_data, bus_last, grant, busy
    );

    modport slave (
        output req, data_in, last, bus_ready,
        input  bus_valid, bus_data, bus_last, grant, busy
    );
endinterface

// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter: one requester at a time owns the shared valid/ready bus for a packet,
// capped at MAX_BEATS transfers, with one idle cycle between successive owners.
module shared_bus_arbiter #(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    shared_bus_if.master bus
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(MAX_BEATS + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state, state_next;
    logic [IW-1:0] owner, owner_next;
    logic [IW-1:0] rr_ptr, rr_next;
    logic [CW-1:0] beat_cnt, beat_next;

    logic          req_own;
    logic          last_own;
    logic [W-1:0]  data_own;
    logic          found;
    int            idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            rr_ptr   <= rr_next;
            beat_cnt <= beat_next;
        end
    end

    // Only the registered owner's lane is ever selected onto the shared bus.
    always_comb begin
        req_own  = 1'b0;
        last_own = 1'b0;
        data_own = '0;
        for (int i = 0; i < N; i++) begin
            if (owner == IW'(i)) begin
                req_own  = bus.req[i];
                last_own = bus.last[i];
                data_own = bus.data_in[i*W +: W];
            end
        end
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        rr_next    = rr_ptr;
        beat_next  = beat_cnt;
        found      = 1'b0;
        idx        = 0;
        case (state)
            IDLE: begin
                for (int k = 0; k < N; k++) begin
                    idx = int'(rr_ptr) + k;
                    if (idx >= N) idx = idx - N;
                    if (!found && bus.req[idx]) begin
                        found      = 1'b1;
                        owner_next = IW'(idx);
                    end
                end
                if (found) begin
                    state_next = OWN;
                    beat_next  = '0;
                end
            end
            OWN: begin
                // Abort, last beat, or the beat limit all hand the bus back through IDLE.
                if (!req_own || (bus.bus_ready && (last_own || beat_cnt == CW'(MAX_BEATS - 1)))) begin
                    state_next = IDLE;
                    beat_next  = '0;
                    rr_next    = (owner == IW'(N - 1)) ? '0 : owner + IW'(1);
                end else if (bus.bus_ready) begin
                    beat_next = beat_cnt + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.grant     = '0;
        bus.bus_valid = 1'b0;
        bus.bus_data  = '0;
        bus.bus_last  = 1'b0;
        bus.busy      = 1'b0;
        if (state == OWN) begin
            bus.busy      = 1'b1;
            bus.bus_valid = req_own;
            bus.bus_data  = data_own;
            bus.bus_last  = last_own;
            for (int i = 0; i < N; i++) begin
                bus.grant[i] = (owner == IW'(i));
            end
        end
    end
endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Checks shared_bus_arbiter with a hand-derived vector table, directed multi-cycle
// sequences, and a long random run against a packet-level reference model.
module tb_shared_bus_arbiter;
    localparam int N         = 4;
    localparam int W         = 8;
    localparam int MAX_BEATS = 16;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    shared_bus_if #(.N(N), .W(W)) bus ();

    shared_bus_arbiter #(.N(N), .W(W), .MAX_BEATS(MAX_BEATS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] last;
        logic       ready;
        logic [3:0] exp_grant;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_last;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];

    // Reference model: owner index (-1 when nobody owns the bus), next-search start, beats so far.
    int m_own;
    int m_rr;
    int m_beats;

    function automatic void add_vec(input logic rst, input logic [3:0] req, input logic [3:0] last,
                                    input logic ready, input logic [3:0] g, input logic v,
                                    input logic [7:0] d, input logic l, input logic b);
        vec_t x;
        x.rst = rst; x.req = req; x.last = last; x.ready = ready;
        x.exp_grant = g; x.exp_valid = v; x.exp_data = d; x.exp_last = l; x.exp_busy = b;
        vecs.push_back(x);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] last, input logic ready);
        bus.req       = req;
        bus.last      = last;
        bus.bus_ready = ready;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_cycle(input string name, input logic [3:0] g, input logic v);
        #1;
        checkOutput({name, "_grant"}, 32'(bus.grant), 32'(g));
        checkOutput({name, "_valid"}, 32'(bus.bus_valid), 32'(v));
        @(negedge clk);
    endtask

    task automatic model_update();
        if (m_own < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_own < 0 && bus.req[(m_rr + k) % N]) begin
                    m_own   = (m_rr + k) % N;
                    m_beats = 0;
                end
            end
        end else if (!bus.req[m_own]) begin
            m_rr  = (m_own + 1) % N;
            m_own = -1;
        end else if (bus.bus_ready) begin
            m_beats++;
            if (bus.last[m_own] || m_beats == MAX_BEATS) begin
                m_rr  = (m_own + 1) % N;
                m_own = -1;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] exp_g;
        logic       exp_v;
        logic [7:0] exp_d;
        logic       exp_l;

        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        bus.data_in  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        applyStimulus(4'b0000, 4'b0000, 1'b0);

        // Single source: three beats from source 1, then the pointer sits at 2.
        add_vec(1, 4'b0010, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 0);
        add_vec(0, 4'b0010, 4'b0000, 1, 4'b0010, 1, 8'hA1, 0, 1);
        add_vec(0, 4'b0010, 4'b0000, 1, 4'b0010, 1, 8'hA1, 0, 1);
        add_vec(0, 4'b0010, 4'b0010, 1, 4'b0010, 1, 8'hA1, 1, 1);
        add_vec(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 0);
        add_vec(0, 4'b1111, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 0);
        add_vec(0, 4'b1111, 4'b0000, 1, 4'b0100, 1, 8'hA2, 0, 1);
        // Round-robin rotation of one-beat packets with an idle cycle between owners.
        add_vec(1, 4'b1111, 4'b1111, 1, 4'b0000, 0, 8'h00, 0, 0);
        add_vec(0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 8'hA0, 1, 1);
        add_vec(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 8'h00, 0, 0);
        add_vec(0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 8'hA1, 1, 1);
        add_vec(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 8'h00, 0, 0);
        add_vec(0, 4'b1111, 4'b1111, 1, 4'b0100, 1, 8'hA2, 1, 1);
        add_vec(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 8'h00, 0, 0);
        add_vec(0, 4'b1111, 4'b1111, 1, 4'b1000, 1, 8'hA3, 1, 1);
        add_vec(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 8'h00, 0, 0);
        add_vec(0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 8'hA0, 1, 1);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            applyStimulus(vecs[i].req, vecs[i].last, vecs[i].ready);
            #1;
            checkOutput($sformatf("vec%0d_grant", i), 32'(bus.grant), 32'(vecs[i].exp_grant));
            checkOutput($sformatf("vec%0d_valid", i), 32'(bus.bus_valid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("vec%0d_data", i), 32'(bus.bus_data), 32'(vecs[i].exp_data));
            checkOutput($sformatf("vec%0d_last", i), 32'(bus.bus_last), 32'(vecs[i].exp_last));
            checkOutput($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].exp_busy));
            @(negedge clk);
        end

        // Beat limit: source 0 never sends last, so the 16th transfer forces release.
        do_reset();
        applyStimulus(4'b0011, 4'b0000, 1'b1);
        check_cycle("limit_idle", 4'b0000, 1'b0);
        for (int b = 0; b < MAX_BEATS; b++) check_cycle($sformatf("limit_beat%0d", b), 4'b0001, 1'b1);
        check_cycle("limit_gap", 4'b0000, 1'b0);
        check_cycle("limit_next", 4'b0010, 1'b1);

        // Stall keeps ownership and the beat count; an abort releases without a transfer.
        do_reset();
        applyStimulus(4'b0001, 4'b0000, 1'b1);
        check_cycle("stall_idle", 4'b0000, 1'b0);
        check_cycle("stall_beat0", 4'b0001, 1'b1);
        check_cycle("stall_beat1", 4'b0001, 1'b1);
        applyStimulus(4'b0001, 4'b0000, 1'b0);
        for (int s = 0; s < 5; s++) begin
            check_cycle($sformatf("stall_hold%0d", s), 4'b0001, 1'b1);
            checkOutput($sformatf("stall_cnt%0d", s), 32'(dut.beat_cnt), 32'd2);
        end
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        check_cycle("abort_owned", 4'b0001, 1'b0);
        applyStimulus(4'b0011, 4'b0000, 1'b1);
        checkOutput("abort_cnt", 32'(dut.beat_cnt), 32'd0);
        check_cycle("abort_gap", 4'b0000, 1'b0);
        check_cycle("abort_next", 4'b0010, 1'b1);

        // Asynchronous reset mid-packet while source 1 owns the bus.
        do_reset();
        applyStimulus(4'b1111, 4'b0001, 1'b1);
        check_cycle("arst_idle0", 4'b0000, 1'b0);
        check_cycle("arst_pkt0", 4'b0001, 1'b1);
        applyStimulus(4'b1111, 4'b0000, 1'b1);
        check_cycle("arst_gap", 4'b0000, 1'b0);
        check_cycle("arst_pkt1", 4'b0010, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_grant", 32'(bus.grant), 32'd0);
        checkOutput("arst_valid", 32'(bus.bus_valid), 32'd0);
        checkOutput("arst_data", 32'(bus.bus_data), 32'd0);
        checkOutput("arst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_cycle("arst_after_idle", 4'b0000, 1'b0);
        check_cycle("arst_after_grant", 4'b0001, 1'b1);

        // Random traffic against the packet-level model.
        do_reset();
        m_own   = -1;
        m_rr    = 0;
        m_beats = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                bus.req[i]  = ($urandom_range(3) != 0);
                bus.last[i] = ($urandom_range(4) == 0);
            end
            bus.bus_ready = ($urandom_range(3) != 0);
            bus.data_in   = $urandom;
            #1;
            exp_g = (m_own >= 0) ? (4'b0001 << m_own) : 4'b0000;
            exp_v = (m_own >= 0) ? bus.req[m_own] : 1'b0;
            exp_d = (m_own >= 0) ? bus.data_in[m_own*W +: W] : 8'h00;
            exp_l = (m_own >= 0) ? bus.last[m_own] : 1'b0;
            checkOutput("rand_onehot0", 32'($onehot0(bus.grant)), 32'd1);
            checkOutput("rand_grant", 32'(bus.grant), 32'(exp_g));
            checkOutput("rand_valid", 32'(bus.bus_valid), 32'(exp_v));
            checkOutput("rand_data", 32'(bus.bus_data), 32'(exp_d));
            checkOutput("rand_last", 32'(bus.bus_last), 32'(exp_l));
            checkOutput("rand_busy", 32'(bus.busy), 32'(m_own >= 0));
            @(posedge clk);
            model_update();
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shared_bus_arbiter.md
# shared_bus_arbiter

Round-robin arbiter that gives exactly one of N requesters ownership of a single shared output bus at a time. It is the legal single-driver counterpart to designs where several sources assign the same net: every source drives its own input slice, and only the granted slice reaches the bus. It sits between N packet sources and one downstream valid/ready sink. Each grant holds for a whole packet and is capped by a beat limit.

## Interface
- N, 4: number of requesters (2..16).
- W, 8: data width per requester.
- MAX_BEATS, 16: maximum transfers per grant before forced release (≥1).
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  request per source; must stay high while that source has data.
- data_in  input  N*W  source i data on bits [i*W +: W].
- last  input  N  source i marks its final beat.
- bus_ready  input  1  sink accepts the current beat.
- bus_valid  output  1  beat present on bus_data.
- bus_data  output  W  granted source data; zero when no owner.
- bus_last  output  1  last[owner] while owned, else 0.
- grant  output  N  one-hot owner, or all zero.
- busy  output  1  high in the OWN state.

## Operation
- States: IDLE and OWN. Registers:
  - owner index, $clog2(N) bits.
  - rr_ptr, $clog2(N) bits.
  - beat_cnt, $clog2(MAX_BEATS+1) bits.
- IDLE:
  - grant=0, bus_valid=0.
  - If req≠0, pick the first set bit searching upward from rr_ptr, wrapping past N-1 to 0.
  - Load owner, set grant one-hot, clear beat_cnt, go to OWN.
- OWN:
  - bus_valid = req[owner].
  - bus_data = data_in slice of owner, through a combinational mux. No other slice ever reaches bus_data.
  - A transfer occurs when bus_valid & bus_ready. Each transfer increments beat_cnt.
- Release from OWN to IDLE happens at the edge after any of these:
  - a transfer with last[owner]=1;
  - a transfer that makes beat_cnt reach MAX_BEATS (forced release, even without last);
  - req[owner]=0 (abort; the beat is not transferred).
- On release:
  - rr_ptr ← owner+1 mod N; with N not a power of two, owner N-1 wraps to 0.
  - grant clears and beat_cnt clears.
- Every release is followed by exactly one IDLE cycle with grant=0 (no back-to-back handover). Two grants therefore never overlap.
- Non-owner req and last bits are ignored while in OWN.

## Timing
- Reset values: grant=0, bus_valid=0, bus_data=0, bus_last=0, busy=0, state=IDLE, rr_ptr=0, owner=0, beat_cnt=0.
- Reset is asynchronous: asserting rst_n mid-packet drops grant and bus_valid immediately, without waiting for a clock edge.
- Arbitration latency: req rises before edge k in IDLE → grant and busy high after edge k. bus_valid is high in that same cycle if req is still high.
- bus_valid, bus_data and bus_last are combinational from req, data_in and last, gated by the registered owner.
- Packet turnaround: last transfer at edge k → grant=0 during cycle k..k+1 → next grant after edge k+1.
- A stall (bus_ready=0) holds ownership and beat_cnt indefinitely. There is no timeout other than beat-limited release.
- MAX_BEATS=1: every transfer releases.

## Test plan
- **Single source.** After reset, req=4'b0010, bus_ready=1, last on the 3rd beat. Required:
  - grant=0010 one cycle after req rises;
  - 3 transfers with bus_data = slice 1;
  - grant=0 for one cycle, then rr_ptr=2.
- **Round-robin rotation.** req=4'b1111 held, each packet 1 beat with last=1. Required: grants 0001, 0010, 0100, 1000, 0001, each separated by one idle cycle.
- **Beat-limit release.** MAX_BEATS=16, source 0 streams with last=0. Required:
  - forced release after the 16th transfer;
  - source 1 (also requesting) granted 2 cycles later.
- **Stall and abort.** bus_ready=0 for 5 cycles mid-packet: grant is held, beat_cnt unchanged. Then req[owner] drops with bus_ready=0: release with no transfer counted.
- **Async reset mid-packet.** rst_n low between edges during a grant → grant=0 and bus_valid=0 immediately. After release with req=1111, first grant is 0001 (rr_ptr=0).
- **Single-driver check.** Random req, last and bus_ready for 10k cycles. Required:
  - $onehot0(grant) always holds;
  - bus_data is 0 whenever grant=0;
  - bus_data equals the data_in slice of the owner otherwise.
